// File: rtl/fp_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : fp_issue_scoreboard
// Purpose  : Issue/writeback controller between FP decode and the FPU.
//            Tracks up to DEPTH in-flight ops by tag, blocks RAW/WAW hazards
//            on FP registers, accepts out-of-order completions, registers
//            writebacks and accrues sticky fflags.
// Revision : 1.0 - initial release
// ============================================================================
module fp_issue_scoreboard #(
  parameter int FLEN      = 32,
  parameter int DEPTH     = 4,
  parameter int NUM_FREGS = 32,
  parameter int TAG_W     = $clog2(DEPTH)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  // core-side request
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [2:0][4:0]              req_rs_i,
  input  logic [2:0]                   req_rs_used_i,
  input  logic [4:0]                   req_rd_i,
  input  logic                         req_rd_int_i,
  input  logic                         req_wr_en_i,
  // FPU issue side
  output logic                         fpu_valid_o,
  input  logic                         fpu_ready_i,
  output logic [TAG_W-1:0]             fpu_tag_o,
  // FPU result side
  input  logic                         fpu_out_valid_i,
  input  logic [TAG_W-1:0]             fpu_tag_i,
  input  logic [FLEN-1:0]              fpu_result_i,
  input  logic [4:0]                   fpu_status_i,
  // control
  input  logic                         flush_i,
  // writeback
  output logic                         wb_valid_o,
  output logic                         wb_int_o,
  output logic [4:0]                   wb_rd_o,
  output logic [FLEN-1:0]              wb_data_o,
  // status
  output logic [4:0]                   fflags_o,
  input  logic                         fflags_clr_i,
  output logic [$clog2(DEPTH+1)-1:0]   inflight_cnt_o,
  output logic                         busy_o
);

  localparam int CNT_W = $clog2(DEPTH+1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DEPTH-1:0]        alloc_q,    alloc_d;
  logic [DEPTH-1:0][4:0]   slot_rd_q,  slot_rd_d;
  logic [DEPTH-1:0]        slot_int_q, slot_int_d;
  logic [DEPTH-1:0]        slot_wr_q,  slot_wr_d;
  logic [NUM_FREGS-1:0]    sb_q,       sb_d;
  logic                    wb_valid_q, wb_valid_d;
  logic                    wb_int_q,   wb_int_d;
  logic [4:0]              wb_rd_q,    wb_rd_d;
  logic [FLEN-1:0]         wb_data_q,  wb_data_d;
  logic [4:0]              fflags_q,   fflags_d;
  logic [CNT_W-1:0]        cnt_q,      cnt_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [31:0]             sb_full;
  logic                    raw_hit;
  logic                    waw_hit;
  logic                    hazard;
  logic                    any_free;
  logic [TAG_W-1:0]        free_idx;
  logic                    can_issue;
  logic                    fire;
  logic                    cpl;
  logic                    cpl_wb;
  logic                    cpl_sb_clr;
  logic [4:0]              cpl_rd;
  logic [NUM_FREGS-1:0]    sb_set;
  logic [NUM_FREGS-1:0]    sb_clr;

  // Register indices beyond NUM_FREGS read as "never busy".
  for (genvar r = 0; r < 32; r++) begin : g_sb_pad
    if (r < NUM_FREGS) begin : g_tracked
      assign sb_full[r] = sb_q[r];
    end else begin : g_untracked
      assign sb_full[r] = 1'b0;
    end
  end

  // RAW check across the three source operands.
  always_comb begin
    raw_hit = 1'b0;
    for (int s = 0; s < 3; s++) begin
      if (req_rs_used_i[s] && sb_full[req_rs_i[s]]) raw_hit = 1'b1;
    end
  end

  // Integer destinations are interlocked by the core, so only FP rd is checked.
  assign waw_hit = req_wr_en_i & ~req_rd_int_i & sb_full[req_rd_i];
  assign hazard  = raw_hit | waw_hit;

  // Lowest-index free slot from the start-of-cycle allocation vector.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!alloc_q[i]) begin
        any_free = 1'b1;
        free_idx = TAG_W'(i);
      end
    end
  end

  assign can_issue   = req_valid_i & ~hazard & any_free & ~flush_i;
  assign fpu_valid_o = can_issue;
  assign req_ready_o = can_issue & fpu_ready_i;
  assign fire        = req_ready_o;
  assign fpu_tag_o   = free_idx;

  // Results for unallocated tags and results racing a flush are dropped.
  assign cpl        = fpu_out_valid_i & alloc_q[fpu_tag_i] & ~flush_i;
  assign cpl_wb     = cpl & slot_wr_q[fpu_tag_i];
  assign cpl_sb_clr = cpl & slot_wr_q[fpu_tag_i] & ~slot_int_q[fpu_tag_i];
  assign cpl_rd     = slot_rd_q[fpu_tag_i];

  // Per-register set on issue / clear on completion decode.
  for (genvar r = 0; r < NUM_FREGS; r++) begin : g_sb_next
    assign sb_set[r] = fire & req_wr_en_i & ~req_rd_int_i & (req_rd_i == 5'(r));
    assign sb_clr[r] = cpl_sb_clr & (cpl_rd == 5'(r));
  end

  assign sb_d = flush_i ? '0 : ((sb_q & ~sb_clr) | sb_set);

  // Slot table next state: free on completion, allocate on fire, wipe on flush.
  always_comb begin
    alloc_d    = alloc_q;
    slot_rd_d  = slot_rd_q;
    slot_int_d = slot_int_q;
    slot_wr_d  = slot_wr_q;
    if (cpl) begin
      alloc_d[fpu_tag_i] = 1'b0;
    end
    if (fire) begin
      alloc_d[free_idx]    = 1'b1;
      slot_rd_d[free_idx]  = req_rd_i;
      slot_int_d[free_idx] = req_rd_int_i;
      slot_wr_d[free_idx]  = req_wr_en_i;
    end
    if (flush_i) begin
      alloc_d = '0;
    end
  end

  // Writeback and fflags next state; wb payload holds when no new writeback.
  always_comb begin
    wb_valid_d = cpl_wb;
    wb_int_d   = wb_int_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    if (cpl_wb) begin
      wb_int_d  = slot_int_q[fpu_tag_i];
      wb_rd_d   = cpl_rd;
      wb_data_d = fpu_result_i;
    end
    fflags_d = (fflags_clr_i ? 5'b0 : fflags_q) | (cpl ? fpu_status_i : 5'b0);
  end

  // Registered occupancy count of the next allocation vector.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_d = cnt_d + CNT_W'(alloc_d[i]);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alloc_q    <= '0;
      slot_rd_q  <= '0;
      slot_int_q <= '0;
      slot_wr_q  <= '0;
      sb_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_int_q   <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      fflags_q   <= '0;
      cnt_q      <= '0;
    end else begin
      alloc_q    <= alloc_d;
      slot_rd_q  <= slot_rd_d;
      slot_int_q <= slot_int_d;
      slot_wr_q  <= slot_wr_d;
      sb_q       <= sb_d;
      wb_valid_q <= wb_valid_d;
      wb_int_q   <= wb_int_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      fflags_q   <= fflags_d;
      cnt_q      <= cnt_d;
    end
  end

  assign wb_valid_o     = wb_valid_q;
  assign wb_int_o       = wb_int_q;
  assign wb_rd_o        = wb_rd_q;
  assign wb_data_o      = wb_data_q;
  assign fflags_o       = fflags_q;
  assign inflight_cnt_o = cnt_q;
  assign busy_o         = (|alloc_q) | wb_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_issue_scoreboard
// Purpose  : Self-checking bench for fp_issue_scoreboard (DEPTH=4, FLEN=32).
//            Expected writebacks are queued when results are driven and
//            popped by a monitor when the DUT presents them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_issue_scoreboard;

  localparam int FLEN  = 32;
  localparam int DEPTH = 4;
  localparam int TAG_W = 2;
  localparam int CNT_W = 3;

  logic                clk_i = 1'b0;
  logic                rst_i = 1'b1;
  logic                req_valid_i = 1'b0;
  logic                req_ready_o;
  logic [2:0][4:0]     req_rs_i = '0;
  logic [2:0]          req_rs_used_i = '0;
  logic [4:0]          req_rd_i = '0;
  logic                req_rd_int_i = 1'b0;
  logic                req_wr_en_i = 1'b0;
  logic                fpu_valid_o;
  logic                fpu_ready_i = 1'b1;
  logic [TAG_W-1:0]    fpu_tag_o;
  logic                fpu_out_valid_i = 1'b0;
  logic [TAG_W-1:0]    fpu_tag_i = '0;
  logic [FLEN-1:0]     fpu_result_i = '0;
  logic [4:0]          fpu_status_i = '0;
  logic                flush_i = 1'b0;
  logic                wb_valid_o;
  logic                wb_int_o;
  logic [4:0]          wb_rd_o;
  logic [FLEN-1:0]     wb_data_o;
  logic [4:0]          fflags_o;
  logic                fflags_clr_i = 1'b0;
  logic [CNT_W-1:0]    inflight_cnt_o;
  logic                busy_o;

  fp_issue_scoreboard #(.FLEN(FLEN), .DEPTH(DEPTH), .NUM_FREGS(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_rs_i(req_rs_i), .req_rs_used_i(req_rs_used_i),
    .req_rd_i(req_rd_i), .req_rd_int_i(req_rd_int_i), .req_wr_en_i(req_wr_en_i),
    .fpu_valid_o(fpu_valid_o), .fpu_ready_i(fpu_ready_i), .fpu_tag_o(fpu_tag_o),
    .fpu_out_valid_i(fpu_out_valid_i), .fpu_tag_i(fpu_tag_i),
    .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i),
    .flush_i(flush_i),
    .wb_valid_o(wb_valid_o), .wb_int_o(wb_int_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i),
    .inflight_cnt_o(inflight_cnt_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        wint;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t         exp_q[$];
  wb_t         mon_e;
  logic        m_alloc [DEPTH];
  logic [4:0]  m_rd    [DEPTH];
  logic        m_int   [DEPTH];
  logic        m_wr    [DEPTH];
  logic [4:0]  m_flags;

  // Writeback monitor: every presented writeback must match the queue head.
  always @(negedge clk_i) begin
    if (wb_valid_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected got int=%0b rd=%0d data=%h required none", wb_int_o, wb_rd_o, wb_data_o);
      end else begin
        mon_e = exp_q.pop_front();
        if ({wb_int_o, wb_rd_o, wb_data_o} !== mon_e) begin
          errors++;
          $display("FAIL wb_payload got int=%0b rd=%0d data=%h required int=%0b rd=%0d data=%h",
                   wb_int_o, wb_rd_o, wb_data_o, mon_e.wint, mon_e.rd, mon_e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "bench timeout");
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input logic [4:0] rd, input logic rint, input logic wr,
                         input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [2:0] used);
    req_valid_i   = 1'b1;
    req_rd_i      = rd;
    req_rd_int_i  = rint;
    req_wr_en_i   = wr;
    req_rs_i[0]   = r0;
    req_rs_i[1]   = r1;
    req_rs_i[2]   = r2;
    req_rs_used_i = used;
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < DEPTH; i++) if (!m_alloc[i]) return i;
    return -1;
  endfunction

  task automatic model_issue(input int tag);
    m_alloc[tag] = 1'b1;
    m_rd[tag]    = req_rd_i;
    m_int[tag]   = req_rd_int_i;
    m_wr[tag]    = req_wr_en_i;
  endtask

  task automatic model_reset;
    for (int i = 0; i < DEPTH; i++) m_alloc[i] = 1'b0;
    m_flags = '0;
  endtask

  // Drive one FPU result; the model decides whether it is accepted.
  task automatic drive_cpl(input int tag, input logic [31:0] data, input logic [4:0] st);
    fpu_out_valid_i = 1'b1;
    fpu_tag_i       = TAG_W'(tag);
    fpu_result_i    = data;
    fpu_status_i    = st;
    if (m_alloc[tag] && !flush_i && !rst_i) begin
      if (m_wr[tag]) exp_q.push_back({m_int[tag], m_rd[tag], data});
      m_alloc[tag] = 1'b0;
      m_flags      = (fflags_clr_i ? 5'b0 : m_flags) | st;
    end
  endtask

  task automatic end_cpl;
    fpu_out_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    tick; tick;
    rst_i = 1'b0;
    model_reset();
    checks++;
    if ({wb_valid_o, wb_int_o, wb_rd_o, wb_data_o, fflags_o, inflight_cnt_o, busy_o, fpu_valid_o, req_ready_o} !== '0) begin
      errors++;
      $display("FAIL reset_state got wbv=%0b int=%0b rd=%0d data=%h ff=%b cnt=%0d busy=%0b required all zero",
               wb_valid_o, wb_int_o, wb_rd_o, wb_data_o, fflags_o, inflight_cnt_o, busy_o);
    end
  endtask

  task automatic test_basic;
    set_req(5'd3, 1'b0, 1'b1, 5'd1, 5'd2, 5'd0, 3'b011);
    fpu_ready_i = 1'b1;
    #1;
    checks++;
    if ({fpu_valid_o, req_ready_o, fpu_tag_o} !== {2'b11, 2'd0}) begin
      errors++;
      $display("FAIL basic_issue got v=%0b r=%0b tag=%0d required v=1 r=1 tag=0", fpu_valid_o, req_ready_o, fpu_tag_o);
    end
    tick;
    model_issue(0);
    req_valid_i = 1'b0;
    checks++;
    if (inflight_cnt_o !== 3'd1) begin
      errors++;
      $display("FAIL basic_cnt got %0d required 1", inflight_cnt_o);
    end
    set_req(5'd4, 1'b0, 1'b1, 5'd3, 5'd0, 5'd0, 3'b001);
    #1;
    checks++;
    if (req_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_sb_set got ready=%0b required 0", req_ready_o);
    end
    req_valid_i = 1'b0;
    drive_cpl(0, 32'h4040_0000, 5'b0);
    tick;
    end_cpl;
    checks++;
    if ({wb_valid_o, inflight_cnt_o, fflags_o} !== {1'b1, 3'd0, 5'd0}) begin
      errors++;
      $display("FAIL basic_wb got wbv=%0b cnt=%0d ff=%b required wbv=1 cnt=0 ff=0", wb_valid_o, inflight_cnt_o, fflags_o);
    end
    tick;
  endtask

  task automatic test_raw_waw;
    int t;
    int t2;
    t = lowest_free();
    set_req(5'd3, 1'b0, 1'b1, 5'd1, 5'd2, 5'd0, 3'b011);
    tick;
    model_issue(t);
    set_req(5'd4, 1'b0, 1'b1, 5'd3, 5'd5, 5'd0, 3'b011);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (req_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL raw_stall got ready=%0b required 0 (cycle %0d)", req_ready_o, c);
      end
      tick;
    end
    drive_cpl(t, 32'h40c0_0000, 5'b0);
    #1;
    checks++;
    if (req_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL raw_no_bypass got ready=%0b required 0", req_ready_o);
    end
    tick;
    end_cpl;
    t2 = lowest_free();
    #1;
    checks++;
    if ({req_ready_o, fpu_tag_o} !== {1'b1, TAG_W'(t2)}) begin
      errors++;
      $display("FAIL raw_release got ready=%0b tag=%0d required ready=1 tag=%0d", req_ready_o, fpu_tag_o, t2);
    end
    tick;
    model_issue(t2);
    set_req(5'd4, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 3'b000);
    #1;
    checks++;
    if (req_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL waw_stall got ready=%0b required 0", req_ready_o);
    end
    drive_cpl(t2, 32'h4100_0000, 5'b0);
    tick;
    end_cpl;
    #1;
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL waw_release got ready=%0b required 1", req_ready_o);
    end
    req_valid_i = 1'b0;
    tick;
  endtask

  task automatic test_fill_ooo;
    for (int i = 0; i < DEPTH; i++) begin
      set_req(5'(10 + i), 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 3'b000);
      #1;
      checks++;
      if (fpu_tag_o !== TAG_W'(i)) begin
        errors++;
        $display("FAIL fill_tag got %0d required %0d", fpu_tag_o, i);
      end
      tick;
      model_issue(i);
    end
    set_req(5'd14, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 3'b000);
    #1;
    checks++;
    if ({fpu_valid_o, req_ready_o, inflight_cnt_o} !== {2'b00, 3'd4}) begin
      errors++;
      $display("FAIL fill_full got v=%0b r=%0b cnt=%0d required v=0 r=0 cnt=4", fpu_valid_o, req_ready_o, inflight_cnt_o);
    end
    drive_cpl(2, 32'h0000_2222, 5'b0);
    #1;
    checks++;
    if (fpu_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL fill_same_cycle_realloc got v=%0b required 0", fpu_valid_o);
    end
    tick;
    end_cpl;
    checks++;
    if ({fpu_valid_o, fpu_tag_o} !== {1'b1, 2'd2}) begin
      errors++;
      $display("FAIL fill_reuse_tag got v=%0b tag=%0d required v=1 tag=2", fpu_valid_o, fpu_tag_o);
    end
    tick;
    model_issue(2);
    req_valid_i = 1'b0;
    drive_cpl(3, 32'h0000_3333, 5'b0); tick;
    drive_cpl(0, 32'h0000_0a0a, 5'b0); tick;
    drive_cpl(1, 32'h0000_1111, 5'b0); tick;
    drive_cpl(2, 32'h0000_4444, 5'b0); tick;
    end_cpl;
    checks++;
    if (inflight_cnt_o !== 3'd0) begin
      errors++;
      $display("FAIL fill_drain got cnt=%0d required 0", inflight_cnt_o);
    end
    tick;
  endtask

  task automatic test_int_flags;
    int t;
    t = lowest_free();
    set_req(5'd5, 1'b1, 1'b1, 5'd1, 5'd2, 5'd0, 3'b011);
    tick;
    model_issue(t);
    set_req(5'd6, 1'b0, 1'b1, 5'd5, 5'd0, 5'd0, 3'b001);
    #1;
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL int_rd_not_scoreboarded got ready=%0b required 1", req_ready_o);
    end
    req_valid_i = 1'b0;
    drive_cpl(t, 32'h0000_0001, 5'b10000);
    tick;
    end_cpl;
    checks++;
    if (fflags_o !== 5'b10000) begin
      errors++;
      $display("FAIL flags_nv got %b required 10000", fflags_o);
    end
    t = lowest_free();
    set_req(5'd0, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 3'b001);
    tick;
    model_issue(t);
    req_valid_i = 1'b0;
    drive_cpl(t, 32'h0000_dead, 5'b00100);
    tick;
    end_cpl;
    checks++;
    if ({wb_valid_o, fflags_o} !== {1'b0, 5'b10100}) begin
      errors++;
      $display("FAIL flags_no_wr got wbv=%0b ff=%b required wbv=0 ff=10100", wb_valid_o, fflags_o);
    end
    t = lowest_free();
    set_req(5'd7, 1'b0, 1'b1, 5'd1, 5'd0, 5'd0, 3'b001);
    tick;
    model_issue(t);
    req_valid_i = 1'b0;
    fflags_clr_i = 1'b1;
    drive_cpl(t, 32'h3f80_0000, 5'b00001);
    tick;
    end_cpl;
    fflags_clr_i = 1'b0;
    checks++;
    if (fflags_o !== 5'b00001) begin
      errors++;
      $display("FAIL flags_clear_nx got %b required 00001", fflags_o);
    end
    tick;
  endtask

  task automatic test_flush;
    for (int k = 0; k < 3; k++) begin
      set_req(5'(20 + k), 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 3'b000);
      tick;
      model_issue(k);
    end
    req_valid_i = 1'b0;
    drive_cpl(2, 32'h0000_2020, 5'b00010);
    tick;
    flush_i = 1'b1;
    drive_cpl(1, 32'h0000_1111, 5'b01000);
    set_req(5'd23, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 3'b000);
    #1;
    checks++;
    if ({fpu_valid_o, wb_valid_o} !== 2'b01) begin
      errors++;
      $display("FAIL flush_cycle got v=%0b wbv=%0b required v=0 wbv=1", fpu_valid_o, wb_valid_o);
    end
    tick;
    flush_i = 1'b0;
    end_cpl;
    req_valid_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_alloc[i] = 1'b0;
    checks++;
    if ({inflight_cnt_o, busy_o, fflags_o} !== {3'd0, 1'b0, m_flags}) begin
      errors++;
      $display("FAIL flush_state got cnt=%0d busy=%0b ff=%b required cnt=0 busy=0 ff=%b",
               inflight_cnt_o, busy_o, fflags_o, m_flags);
    end
    set_req(5'd20, 1'b0, 1'b1, 5'd21, 5'd22, 5'd0, 3'b011);
    #1;
    checks++;
    if ({req_ready_o, fpu_tag_o} !== {1'b1, 2'd0}) begin
      errors++;
      $display("FAIL flush_sb_clear got ready=%0b tag=%0d required ready=1 tag=0", req_ready_o, fpu_tag_o);
    end
    req_valid_i = 1'b0;
    drive_cpl(0, 32'h0bad_0bad, 5'b11111);
    tick;
    end_cpl;
    checks++;
    if ({inflight_cnt_o, fflags_o, wb_valid_o} !== {3'd0, m_flags, 1'b0}) begin
      errors++;
      $display("FAIL stray_tag got cnt=%0d ff=%b wbv=%0b required cnt=0 ff=%b wbv=0",
               inflight_cnt_o, fflags_o, wb_valid_o, m_flags);
    end
    tick;
  endtask

  task automatic test_backpressure_reset;
    fpu_ready_i = 1'b0;
    set_req(5'd8, 1'b0, 1'b1, 5'd1, 5'd0, 5'd0, 3'b001);
    #1;
    checks++;
    if ({fpu_valid_o, req_ready_o} !== 2'b10) begin
      errors++;
      $display("FAIL bp_handshake got v=%0b r=%0b required v=1 r=0", fpu_valid_o, req_ready_o);
    end
    tick;
    checks++;
    if (inflight_cnt_o !== 3'd0) begin
      errors++;
      $display("FAIL bp_no_alloc got cnt=%0d required 0", inflight_cnt_o);
    end
    fpu_ready_i = 1'b1;
    tick;
    model_issue(0);
    set_req(5'd9, 1'b0, 1'b1, 5'd1, 5'd0, 5'd0, 3'b001);
    tick;
    model_issue(1);
    req_valid_i = 1'b0;
    drive_cpl(0, 32'h0000_5555, 5'b00100);
    tick;
    end_cpl;
    rst_i = 1'b1;
    tick;
    rst_i = 1'b0;
    model_reset();
    checks++;
    if ({wb_valid_o, wb_int_o, wb_rd_o, wb_data_o, fflags_o, inflight_cnt_o, busy_o} !== '0) begin
      errors++;
      $display("FAIL midrst_state got wbv=%0b rd=%0d data=%h ff=%b cnt=%0d busy=%0b required all zero",
               wb_valid_o, wb_rd_o, wb_data_o, fflags_o, inflight_cnt_o, busy_o);
    end
    drive_cpl(1, 32'h0000_6666, 5'b00001);
    tick;
    end_cpl;
    checks++;
    if ({wb_valid_o, fflags_o, inflight_cnt_o} !== '0) begin
      errors++;
      $display("FAIL midrst_late_result got wbv=%0b ff=%b cnt=%0d required all zero", wb_valid_o, fflags_o, inflight_cnt_o);
    end
    tick;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_raw_waw();
    test_fill_ooo();
    test_int_flags();
    test_flush();
    test_backpressure_reset();
    tick;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL wb_missing got %0d outstanding required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fp_issue_scoreboard.md
Name: fp_issue_scoreboard

Overview:
- Parametrised issue/writeback controller between the core-side FP decode and the FPU (fpnew_top), with up to DEPTH FP ops in flight.
- Tracks ops by tag, detects RAW/WAW hazards on FP registers through a per-register scoreboard, and accepts out-of-order FPU completions.
- Delivers registered writebacks to the FP or integer register file and accumulates sticky fflags.

Parameters:
- FLEN, 32, datapath width of operands and results
- DEPTH, 4, max in-flight ops (power of two, 2..16)
- NUM_FREGS, 32, FP registers tracked by the scoreboard
- TAG_W, $clog2(DEPTH), tag width (derived; do not override)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  1  decoded FP op offered by core
- req_ready_o  out  1  op accepted this cycle
- req_rs_i  in  3x5  source FP regs rs1/rs2/rs3
- req_rs_used_i  in  3  per-source use mask
- req_rd_i  in  5  destination register index
- req_rd_int_i  in  1  destination is integer reg (compare, fmv.x.w, fcvt.w.s)
- req_wr_en_i  in  1  op writes a destination
- fpu_valid_o  out  1  issue valid to FPU in_valid_i
- fpu_ready_i  in  1  FPU in_ready_o
- fpu_tag_o  out  TAG_W  tag issued with op
- fpu_out_valid_i  in  1  FPU result valid (out_ready is tied high)
- fpu_tag_i  in  TAG_W  tag of returning result
- fpu_result_i  in  FLEN  result data
- fpu_status_i  in  5  NV/DZ/OF/UF/NX of result
- flush_i  in  1  kill all in-flight ops; also drives FPU flush_i
- wb_valid_o  out  1  writeback valid, one-cycle pulse
- wb_int_o  out  1  writeback targets integer regfile
- wb_rd_o  out  5  writeback register index
- wb_data_o  out  FLEN  writeback data
- fflags_o  out  5  sticky accrued exception flags
- fflags_clr_i  in  1  clear fflags
- inflight_cnt_o  out  $clog2(DEPTH+1)  number of allocated slots
- busy_o  out  1  any slot allocated or wb_valid_o high

Behaviour:
- Reset (rst_i sampled on clk_i edge): all slots free, scoreboard clear; wb_valid_o=0, wb_int_o=0, wb_rd_o=0, wb_data_o=0, fflags_o=0, inflight_cnt_o=0, busy_o=0. rst_i mid-operation drops everything; late FPU results then hit free slots and are ignored.
- hazard = any used rs with its scoreboard bit set, OR (req_wr_en_i & !req_rd_int_i & scoreboard[req_rd_i]). Integer destinations are not scoreboarded; the core interlocks them.
- can_issue = req_valid_i & !hazard & any slot free & !flush_i. fpu_valid_o = can_issue (combinational). req_ready_o = can_issue & fpu_ready_i. fire = req_ready_o.
- On fire: allocate the lowest-index free slot (chosen from start-of-cycle free vector); fpu_tag_o = that index. Slot stores rd, rd_int, wr_en. If wr_en & !rd_int, set scoreboard[rd].
- Completion: fpu_out_valid_i with an allocated slot at fpu_tag_i, and no flush_i, frees that slot at the edge. The same edge clears its scoreboard bit and registers the writeback.
  - wb_valid_o is asserted the next cycle only if the slot's wr_en=1. wb_data_o=fpu_result_i, wb_rd_o/wb_int_o come from the slot.
  - fflags_o |= fpu_status_i regardless of wr_en. Latency result->wb is 1 cycle.
- Completion for a free slot: ignored entirely (no wb, no flags, no state change).
- A slot freed this cycle is not re-allocatable until the next cycle.
- Issue and completion in the same cycle are independent. Scoreboard set and clear cannot target the same rd, because WAW blocks the issue.
- Hazard is evaluated on the start-of-cycle scoreboard, so a dependent op issues at earliest the cycle after its producer completes (no bypass).
- Full: all DEPTH slots allocated -> fpu_valid_o=0, req_ready_o=0.
- flush_i: at the edge, all slots are freed and the scoreboard cleared. Any same-cycle completion is discarded (no wb, no flags). No issue occurs in the flush cycle. A wb_valid_o already registered still presents the next cycle.
- fflags: next = (fflags_clr_i ? 0 : fflags_o) | accepted_status. Same-cycle status survives a clear.
- inflight_cnt_o = popcount of allocated slots (registered). busy_o = |allocated | wb_valid_o.

Test Plan:
- Reset, then issue fadd rd=f3 (rs f1,f2), FPU ready -> fpu_tag_o=0, scoreboard[3]=1, inflight_cnt_o=1. Return tag 0, data 0x40400000, status 0 -> next cycle wb_valid_o=1, wb_rd_o=3, wb_int_o=0, wb_data_o=0x40400000, inflight_cnt_o=0.
- RAW: fmul rd=f3 in flight, then fadd rs1=f3 -> req_ready_o=0 until the cycle after the tag returns, then issues. WAW on rd=f3 also stalls.
- Fill DEPTH=4 with independent ops -> tags 0,1,2,3, fifth held with fpu_valid_o=0. Return tag 2 first -> next request gets tag 2; out-of-order wbs carry the correct rd per tag.
- feq rd_int x5 returns 0x1 with status NV -> wb_int_o=1, wb_rd_o=5, fflags_o=5'b10000. Pulse fflags_clr_i with a concurrent NX result -> fflags_o=5'b00001.
- 3 ops in flight, assert flush_i with a concurrent completion of tag 1 -> no wb, inflight_cnt_o=0, scoreboard clear. Later stray tag 0 return is ignored.
- fpu_ready_i=0 with a valid hazard-free request -> fpu_valid_o=1, req_ready_o=0, no allocation. Assert rst_i mid-stream -> all outputs return to reset values the next cycle.
